// File: rtl/minv_pkg.sv
// minv_pkg: shared sizes, FSM encoding and helpers for the MINV host sequencer.
//   W   operand width in bits
//   DW  MINV word width in bits
//   NW  words per operand
//   IW  word index width
//   CW  shared load/unload cycle counter width (covers NW+RD_LAT-1 for RD_LAT<=3)
//   TW  WAIT timeout counter width
package minv_pkg;
  localparam int W  = 256;
  localparam int DW = 16;
  localparam int NW = W / DW;
  localparam int IW = $clog2(NW);
  localparam int CW = 5;
  localparam int TW = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_P = 3'd2,
    ST_START  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_UNLOAD = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  // Word k of a W-bit operand, least-significant word is k=0.
  function automatic logic [DW-1:0] word_of(input logic [W-1:0] v, input logic [IW-1:0] k);
    return v[int'(k) * DW +: DW];
  endfunction
endpackage

// File: rtl/minv_word_shift.sv
// minv_word_shift: assembles a W-bit value from DW-bit words, one word per strobe.
// Ports:
//   clk   clock
//   rst   asynchronous active-low reset, clears the assembled value
//   load  write strobe for this cycle
//   idx   word slot written when load is high
//   din   word to write
//   q     assembled value
module minv_word_shift
  import minv_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [IW-1:0] idx,
  input  logic [DW-1:0] din,
  output logic [W-1:0]  q
);
  for (genvar gi = 0; gi < NW; gi++) begin : g_word
    logic [DW-1:0] word_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        word_reg <= '0;
      end else if (load && idx == IW'(gi)) begin
        word_reg <= din;
      end
    end

    assign q[gi*DW +: DW] = word_reg;
  end
endmodule

// File: rtl/minv_seq.sv
// minv_seq: host-side sequencer for MINV. Latches a and p on start, streams them to
// MINV word by word (LSW first), pulses minv_en, waits for minv_rdy (with optional
// timeout), then reads x1 back word by word into res_x1 and pulses done.
// Optional feature macro: MINV_SEQ_DBG_EN (outx2/outt follow outx1, res_x2/res_t ports).
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   start, a_in, p_in         host request (start sampled only when idle)
//   busy, done, err           host status
//   res_x1, res_flag          result (valid from done until next start)
//   datain, loada, loadp      word stream towards MINV
//   minv_en                   MINV start pulse
//   outx1, outx2, outt        MINV readout enables
//   regx1out, regx2out, regtout_16   MINV readout words
//   minv_rdy, minv_flag       MINV completion and status
//   res_x2, res_t             (MINV_SEQ_DBG_EN only) x2 and t results
module minv_seq
  import minv_pkg::*;
#(
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 65535
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  a_in,
  input  logic [W-1:0]  p_in,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [W-1:0]  res_x1,
  output logic [1:0]    res_flag,
  output logic [DW-1:0] datain,
  output logic          loada,
  output logic          loadp,
  output logic          minv_en,
  output logic          outx1,
  output logic          outx2,
  output logic          outt,
`ifdef MINV_SEQ_DBG_EN
  output logic [W-1:0]  res_x2,
  output logic [W-1:0]  res_t,
`endif
  input  logic [DW-1:0] regx1out,
  input  logic [DW-1:0] regx2out,
  input  logic [DW-1:0] regtout_16,
  input  logic          minv_rdy,
  input  logic [1:0]    minv_flag
);
  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [TW-1:0] tcnt, tcnt_next;
  logic          err_next;
  logic [1:0]    flag_next;
  logic [W-1:0]  a_reg, p_reg;
  logic          latch;
  logic          cap;
  logic [IW-1:0] cap_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      tcnt     <= '0;
      err      <= 1'b0;
      res_flag <= '0;
      a_reg    <= '0;
      p_reg    <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      tcnt     <= tcnt_next;
      err      <= err_next;
      res_flag <= flag_next;
      if (latch) begin
        a_reg <= a_in;
        p_reg <= p_in;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    tcnt_next  = tcnt;
    err_next   = err;
    flag_next  = res_flag;
    latch      = 1'b0;
    cap        = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    loada      = 1'b0;
    loadp      = 1'b0;
    minv_en    = 1'b0;
    outx1      = 1'b0;
    datain     = '0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          latch      = 1'b1;
          err_next   = 1'b0;
          cnt_next   = '0;
          state_next = ST_LOAD_A;
        end
      end
      ST_LOAD_A: begin
        loada  = 1'b1;
        datain = word_of(a_reg, cnt[IW-1:0]);
        if (cnt == CW'(NW - 1)) begin
          cnt_next   = '0;
          state_next = ST_LOAD_P;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_LOAD_P: begin
        loadp  = 1'b1;
        datain = word_of(p_reg, cnt[IW-1:0]);
        if (cnt == CW'(NW - 1)) begin
          cnt_next   = '0;
          state_next = ST_START;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_START: begin
        minv_en    = 1'b1;
        tcnt_next  = '0;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // minv_rdy is tested first so it wins over a coincident timeout.
        if (minv_rdy) begin
          flag_next  = minv_flag;
          cnt_next   = '0;
          state_next = ST_UNLOAD;
        end else if (TIMEOUT != 0 && tcnt == TW'(TIMEOUT - 1)) begin
          err_next   = 1'b1;
          state_next = ST_DONE;
        end else begin
          tcnt_next = tcnt + 1'b1;
        end
      end
      ST_UNLOAD: begin
        // Enable is held for NW cycles; capture trails it by RD_LAT cycles.
        outx1 = (cnt < CW'(NW));
        cap   = (cnt >= CW'(RD_LAT));
        if (cnt == CW'(NW + RD_LAT - 1)) begin
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign cap_idx = IW'(cnt - CW'(RD_LAT));

  minv_word_shift u_x1 (
    .clk  (clk),
    .rst  (rst),
    .load (cap),
    .idx  (cap_idx),
    .din  (regx1out),
    .q    (res_x1)
  );

`ifdef MINV_SEQ_DBG_EN
  minv_word_shift u_x2 (
    .clk  (clk),
    .rst  (rst),
    .load (cap),
    .idx  (cap_idx),
    .din  (regx2out),
    .q    (res_x2)
  );

  minv_word_shift u_t (
    .clk  (clk),
    .rst  (rst),
    .load (cap),
    .idx  (cap_idx),
    .din  (regtout_16),
    .q    (res_t)
  );

  assign outx2 = outx1;
  assign outt  = outx1;
`else
  assign outx2 = 1'b0;
  assign outt  = 1'b0;

  logic unused_dbg;
  assign unused_dbg = ^{regx2out, regtout_16};
`endif
endmodule

// File: tb/tb_minv_seq.sv
// tb_minv_seq: directed bench for minv_seq with a behavioural MINV responder and a
// transaction-level expectation model checked every cycle on the falling edge.
module tb_minv_seq;
  import minv_pkg::*;

  localparam int RD_LAT = 2;
  localparam int TMO    = 100;
  localparam logic [W-1:0] PAT =
    256'h100f_100e_100d_100c_100b_100a_1009_1008_1007_1006_1005_1004_1003_1002_1001_1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  a_in = '0;
  logic [W-1:0]  p_in = '0;
  logic          busy, done, err;
  logic [W-1:0]  res_x1;
  logic [1:0]    res_flag;
  logic [DW-1:0] datain;
  logic          loada, loadp, minv_en, outx1, outx2, outt;
  logic [DW-1:0] regx1out = '0;
  logic [DW-1:0] regx2out = '0;
  logic [DW-1:0] regtout_16 = '0;
  logic          minv_rdy = 1'b0;
  logic [1:0]    minv_flag = '0;
`ifdef MINV_SEQ_DBG_EN
  logic [W-1:0]  res_x2, res_t;
`endif

  minv_seq #(.RD_LAT(RD_LAT), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a_in       (a_in),
    .p_in       (p_in),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .res_x1     (res_x1),
    .res_flag   (res_flag),
    .datain     (datain),
    .loada      (loada),
    .loadp      (loadp),
    .minv_en    (minv_en),
    .outx1      (outx1),
    .outx2      (outx2),
    .outt       (outt),
`ifdef MINV_SEQ_DBG_EN
    .res_x2     (res_x2),
    .res_t      (res_t),
`endif
    .regx1out   (regx1out),
    .regx2out   (regx2out),
    .regtout_16 (regtout_16),
    .minv_rdy   (minv_rdy),
    .minv_flag  (minv_flag)
  );

  initial forever #5 clk = ~clk;

  // MINV behavioural responder configuration (written by the stimulus only)
  int            rdy_delay = 0;
  logic [1:0]    flag_val = '0;
  logic [DW-1:0] resp [NW];

  // Transaction expectations (written by the stimulus only)
  logic [W-1:0]  exp_a = '0, exp_p = '0, exp_res = '0, pin_res = '0;
  logic [W-1:0]  model_res = '0;
  logic [1:0]    exp_flag = '0, model_flag = '0;
  bit            exp_err = 1'b0, pin_res_on = 1'b0, pin_busy_on = 1'b0;
  int            exp_busy = 0, exp_nx1 = 0, pin_busy = 0;
  int            txn_id = 0;

  // Compare process state
  int nvec = 0, nerr = 0;
  int seen_txn = 0, na = 0, np = 0, nen = 0, nx1 = 0, nbusy = 0;
  bit post_done = 1'b0;

  // MINV model: rdy rdy_delay cycles after minv_en, words delivered RD_LAT after outx1.
  bit wact = 1'b0, uact = 1'b0;
  int wk = 0, uc = 0;
  always @(negedge clk) begin
    if (!rst) begin
      wact      = 1'b0;
      uact      = 1'b0;
      minv_rdy  = 1'b0;
      minv_flag = '0;
      regx1out  = '0;
    end else begin
      minv_rdy = 1'b0;
      if (wact) begin
        wk++;
        if (rdy_delay != 0 && wk == rdy_delay) begin
          minv_rdy  = 1'b1;
          minv_flag = flag_val;
          wact      = 1'b0;
        end
      end
      if (minv_en) begin
        wact = 1'b1;
        wk   = 0;
      end
      if (outx1 && !uact) begin
        uact = 1'b1;
        uc   = 0;
      end
      if (uact) begin
        regx1out = (uc >= RD_LAT && uc < RD_LAT + NW) ? resp[uc - RD_LAT] : 16'hdead;
        uc++;
        if (uc == NW + RD_LAT) uact = 1'b0;
      end else begin
        regx1out = 16'hbeef;
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_ctl", W'({busy, done, err, res_flag, datain, loada, loadp, minv_en, outx1, outx2, outt}), '0);
      chk("rst_res_x1", res_x1, '0);
      post_done = 1'b0;
    end else begin
      if (txn_id != seen_txn) begin
        seen_txn = txn_id;
        na = 0; np = 0; nen = 0; nx1 = 0; nbusy = 0;
      end
      if (post_done) begin
        chk("after_done_idle", W'({busy, done}), '0);
        post_done = 1'b0;
      end
      if (loada && loadp) chk("loada_loadp_exclusive", W'({loada, loadp}), W'(2'b10));
`ifdef MINV_SEQ_DBG_EN
      chk("dbg_enables", W'({outx2, outt}), W'({outx1, outx1}));
`else
      chk("dbg_enables_off", W'({outx2, outt}), '0);
`endif
      if (loada) begin
        chk($sformatf("a_word%0d", na), W'(datain), W'(exp_a[16*(na%NW) +: 16]));
        na++;
      end
      if (loadp) begin
        chk($sformatf("p_word%0d", np), W'(datain), W'(exp_p[16*(np%NW) +: 16]));
        np++;
      end
      if (minv_en) begin
        chk("start_datain", W'(datain), '0);
        nen++;
      end
      if (outx1) nx1++;
      if (busy) nbusy++;
      if (done) begin
        chk("done_err", W'(err), W'(exp_err));
        chk("done_res_x1", res_x1, exp_res);
        chk("done_res_flag", W'(res_flag), W'(exp_flag));
        chk("loada_cycles", W'(na), W'(NW));
        chk("loadp_cycles", W'(np), W'(NW));
        chk("minv_en_cycles", W'(nen), W'(1));
        chk("outx1_cycles", W'(nx1), W'(exp_nx1));
        chk("busy_cycles", W'(nbusy), W'(exp_busy));
        if (pin_res_on) chk("pin_res_x1", res_x1, pin_res);
        if (pin_busy_on) chk("pin_busy_cycles", W'(nbusy), W'(pin_busy));
        $display("txn %0d: err=%0b flag=%b busy=%0d res_x1=0x%0h", txn_id, err, res_flag, nbusy, res_x1);
        post_done = 1'b1;
      end
    end
  end

  task automatic begin_txn(input logic [W-1:0] a, input logic [W-1:0] p, input logic [W-1:0] rv,
                           input int dly, input logic [1:0] flg,
                           input bit pr_on, input logic [W-1:0] pr, input int pb);
    bit terr;
    @(posedge clk);
    #2;
    terr = (dly == 0) || (dly > TMO);
    for (int k = 0; k < NW; k++) resp[k] = rv[16*k +: 16];
    rdy_delay = dly;
    flag_val  = flg;
    exp_a     = a;
    exp_p     = p;
    exp_err   = terr;
    exp_busy  = terr ? (2*NW + 1) + TMO + 1 : (2*NW + 1) + dly + (NW + RD_LAT) + 1;
    exp_nx1   = terr ? 0 : NW;
    if (!terr) begin
      model_res  = rv;
      model_flag = flg;
    end
    exp_res     = model_res;
    exp_flag    = model_flag;
    pin_res_on  = pr_on;
    pin_res     = pr;
    pin_busy_on = (pb != 0);
    pin_busy    = pb;
    a_in  = a;
    p_in  = p;
    start = 1'b1;
    txn_id++;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 1000);
    if (!done) begin
      $display("FAIL wait_done: done=0 after %0d cycles, required a done pulse", n);
      $fatal(1);
    end
  endtask

  task automatic wait_loadp();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!loadp && n < 100);
    if (!loadp) begin
      $display("FAIL wait_loadp: loadp=0 after %0d cycles, required 1", n);
      $fatal(1);
    end
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // a=5, p=11 -> inverse 9; short MINV compute
    begin_txn(256'd5, 256'd11, 256'd9, 5, 2'b01, 1'b1, 256'd9, 0);
    wait_done();

    // 40-cycle compute, flag 2'b10, word k = 0x1000+k checks capture alignment
    begin_txn({8{32'hdeadbeef}}, {8{32'h12345678}}, PAT, 40, 2'b10, 1'b1, PAT, 33 + 40 + 18 + 1);
    wait_done();

    // minv_rdy never arrives: timeout, res_x1 keeps the previous result
    begin_txn(256'd77, 256'd101, {16{16'hffff}}, 0, 2'b11, 1'b1, PAT, 33 + 100 + 1);
    wait_done();

    // minv_rdy on the same cycle the timeout would fire: rdy wins, err cleared
    begin_txn(256'h0abc_0000_0000_0001, 256'h0fff_ffff, 256'h4242, 100, 2'b01, 1'b1, 256'h4242, 33 + 100 + 18 + 1);
    wait_done();

    // start during LOAD_P with new operands must be ignored
    begin_txn(256'd7, 256'd13, 256'd2, 3, 2'b00, 1'b1, 256'd2, 0);
    wait_loadp();
    @(posedge clk);
    #2;
    a_in  = 256'd99;
    p_in  = 256'd98;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done();

    // one-cycle reset in the middle of LOAD_P aborts the operation
    begin_txn(256'd123, 256'd457, 256'd1, 4, 2'b01, 1'b0, '0, 0);
    wait_loadp();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    model_res  = '0;
    model_flag = '0;
    @(posedge clk);
    #2 rst = 1'b1;

    // clean rerun after the abort: 3*5 = 1 mod 7
    begin_txn(256'd3, 256'd7, 256'd5, 2, 2'b01, 1'b1, 256'd5, 33 + 2 + 18 + 1);
    wait_done();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
